// File: rtl/sound_pkg.sv
// Shared constants and step-decode helper for the sound frame sequencer.
package sound_pkg;

  // Channel index within the 4-bit per-channel vectors
  localparam int CH_SQ1   = 0;
  localparam int CH_SQ2   = 1;
  localparam int CH_WAVE  = 2;
  localparam int CH_NOISE = 3;

  // Full-scale length counts
  localparam int LEN_MAX_SQ   = 64;
  localparam int LEN_MAX_WAVE = 256;

  // Length counters are wide enough to hold the WAVE full-scale value
  localparam int CNT_W = 9;

  // Bit n set = strobe fires when the sequencer enters step n
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

  typedef struct packed {
    logic length;
    logic sweep;
    logic env;
  } strobe_t;

  // Which strobes belong to a given sequencer step
  function automatic strobe_t decode_step(input logic [2:0] step);
    strobe_t s;
    s.length = LEN_STEPS[step];
    s.sweep  = SWEEP_STEPS[step];
    s.env    = ENV_STEPS[step];
    return s;
  endfunction

endpackage

// File: rtl/sound_length_counter.sv
// One channel's length counter and channel-active status bit.
module sound_length_counter
  import sound_pkg::*;
#(
  parameter int MAX    = LEN_MAX_SQ,
  parameter int LOAD_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              master_en,
  input  logic              trig,
  input  logic              len_en,
  input  logic              len_load,
  input  logic [LOAD_W-1:0] len_data,
  input  logic              dac_en,
  input  logic              length_tick,
  output logic              active
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             expire;
  logic             active_next;

  // Counter update: load beats trigger reload, which beats a length decrement
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    cnt_next = cnt;
    expire   = 1'b0;
    if (len_load) begin
      cnt_next = MAX_V - CNT_W'(len_data);
    end else if (trig) begin
      if (cnt == '0) cnt_next = MAX_V;
    end else if (length_tick && len_en && (cnt != '0)) begin
      cnt_next = cnt - ONE;
      expire   = (cnt == ONE);
    end
  end

  // Active bit: DAC off wins, then trigger sets it, then expiry clears it
  always_comb begin
    active_next = active;
    if (!dac_en)     active_next = 1'b0;
    else if (trig)   active_next = 1'b1;
    else if (expire) active_next = 1'b0;
  end

  // State register; powering the block off behaves exactly like reset
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
    if (reset || !master_en) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      active <= active_next;
    end
  end

endmodule

// File: rtl/sound_frame_sequencer.sv
// 512 Hz frame sequencer, channel strobes, trigger pulses and length/active status.
module sound_frame_sequencer
  import sound_pkg::*;
#(
  parameter int FRAME_DIV = 8192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       master_en,
  input  logic [3:0] trig,
  input  logic [3:0] len_en,
  input  logic [3:0] len_load,
  input  logic [5:0] len_data_sq1,
  input  logic [5:0] len_data_sq2,
  input  logic [7:0] len_data_wave,
  input  logic [5:0] len_data_noise,
  input  logic [3:0] dac_en,
  output logic [2:0] frame_step,
  output logic       length_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic [3:0] ch_start,
  output logic [3:0] ch_active
);

  localparam int PW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(FRAME_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    step_next;
  strobe_t       strobe_next;

  assign step_next   = frame_step + 3'd1;
  assign strobe_next = decode_step(step_next);

  // Prescaler and step counter; strobes are registered from the step being entered
  always_ff @(posedge clk) begin
    if (reset || !master_en) begin
      prescaler   <= '0;
      frame_step  <= '0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else if (prescaler == PRE_LAST) begin
      prescaler   <= '0;
      frame_step  <= step_next;
      length_tick <= strobe_next.length;
      sweep_tick  <= strobe_next.sweep;
      env_tick    <= strobe_next.env;
    end else begin
      prescaler   <= prescaler + PW'(1);
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end
  end

  // One-cycle restart pulse to each channel datapath, only for DAC-enabled channels
  always_ff @(posedge clk) begin
    if (reset || !master_en) ch_start <= '0;
    else                     ch_start <= trig & dac_en;
  end

  sound_length_counter #(.MAX(LEN_MAX_SQ), .LOAD_W(6)) u_len_sq1 (
    .clk         (clk),
    .reset       (reset),
    .master_en   (master_en),
    .trig        (trig[CH_SQ1]),
    .len_en      (len_en[CH_SQ1]),
    .len_load    (len_load[CH_SQ1]),
    .len_data    (len_data_sq1),
    .dac_en      (dac_en[CH_SQ1]),
    .length_tick (length_tick),
    .active      (ch_active[CH_SQ1])
  );

  sound_length_counter #(.MAX(LEN_MAX_SQ), .LOAD_W(6)) u_len_sq2 (
    .clk         (clk),
    .reset       (reset),
    .master_en   (master_en),
    .trig        (trig[CH_SQ2]),
    .len_en      (len_en[CH_SQ2]),
    .len_load    (len_load[CH_SQ2]),
    .len_data    (len_data_sq2),
    .dac_en      (dac_en[CH_SQ2]),
    .length_tick (length_tick),
    .active      (ch_active[CH_SQ2])
  );

  sound_length_counter #(.MAX(LEN_MAX_WAVE), .LOAD_W(8)) u_len_wave (
    .clk         (clk),
    .reset       (reset),
    .master_en   (master_en),
    .trig        (trig[CH_WAVE]),
    .len_en      (len_en[CH_WAVE]),
    .len_load    (len_load[CH_WAVE]),
    .len_data    (len_data_wave),
    .dac_en      (dac_en[CH_WAVE]),
    .length_tick (length_tick),
    .active      (ch_active[CH_WAVE])
  );

  sound_length_counter #(.MAX(LEN_MAX_SQ), .LOAD_W(6)) u_len_noise (
    .clk         (clk),
    .reset       (reset),
    .master_en   (master_en),
    .trig        (trig[CH_NOISE]),
    .len_en      (len_en[CH_NOISE]),
    .len_load    (len_load[CH_NOISE]),
    .len_data    (len_data_noise),
    .dac_en      (dac_en[CH_NOISE]),
    .length_tick (length_tick),
    .active      (ch_active[CH_NOISE])
  );

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Self-checking bench for sound_frame_sequencer with a time-based reference model.
module tb_sound_frame_sequencer;

  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       master_en;
  logic [3:0] trig, len_en, len_load, dac_en;
  logic [5:0] len_data_sq1, len_data_sq2, len_data_noise;
  logic [7:0] len_data_wave;
  logic [2:0] frame_step;
  logic       length_tick, sweep_tick, env_tick;
  logic [3:0] ch_start, ch_active;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sound_frame_sequencer #(.FRAME_DIV(FD)) dut (
    .clk            (clk),
    .reset          (reset),
    .master_en      (master_en),
    .trig           (trig),
    .len_en         (len_en),
    .len_load       (len_load),
    .len_data_sq1   (len_data_sq1),
    .len_data_sq2   (len_data_sq2),
    .len_data_wave  (len_data_wave),
    .len_data_noise (len_data_noise),
    .dac_en         (dac_en),
    .frame_step     (frame_step),
    .length_tick    (length_tick),
    .sweep_tick     (sweep_tick),
    .env_tick       (env_tick),
    .ch_start       (ch_start),
    .ch_active      (ch_active)
  );

  // Internal length counts, observed for checking only
  logic [8:0] c_sq1, c_sq2, c_wave, c_noise;
  assign c_sq1   = dut.u_len_sq1.cnt;
  assign c_sq2   = dut.u_len_sq2.cnt;
  assign c_wave  = dut.u_len_wave.cnt;
  assign c_noise = dut.u_len_noise.cnt;

  function automatic logic [8:0] dut_cnt(input int i);
    case (i)
      0:       return c_sq1;
      1:       return c_sq2;
      2:       return c_wave;
      default: return c_noise;
    endcase
  endfunction

  function automatic logic [13:0] dut_vec();
    return {frame_step, length_tick, sweep_tick, env_tick, ch_start, ch_active};
  endfunction

  // ---------------- reference model ----------------
  // Timing is derived from the number of enabled cycles since power-up:
  // step = (cycles / FD) mod 8, and a strobe is visible on every FD-th cycle.
  int         en_cyc = 0;
  int         m_step = 0;
  int         m_cnt[4] = '{0, 0, 0, 0};
  logic [3:0] m_act = 4'b0;
  logic [3:0] m_start = 4'b0;
  logic       m_lt = 1'b0, m_st = 1'b0, m_et = 1'b0;
  logic       m_tick_now, m_exp;
  int         m_data;

  function automatic int max_of(input int i);
    return (i == 2) ? 256 : 64;
  endfunction

  function automatic int data_of(input int i);
    case (i)
      0:       return int'(len_data_sq1);
      1:       return int'(len_data_sq2);
      2:       return int'(len_data_wave);
      default: return int'(len_data_noise);
    endcase
  endfunction

  function automatic logic [13:0] model_vec();
    return {3'(m_step), m_lt, m_st, m_et, m_start, m_act};
  endfunction

  always @(posedge clk) begin
    m_tick_now = m_lt;
    if (reset || !master_en) begin
      en_cyc  = 0;
      m_step  = 0;
      m_act   = 4'b0;
      m_start = 4'b0;
      m_lt    = 1'b0;
      m_st    = 1'b0;
      m_et    = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_exp  = 1'b0;
        m_data = data_of(i);
        if (len_load[i]) begin
          m_cnt[i] = max_of(i) - m_data;
        end else if (trig[i]) begin
          if (m_cnt[i] == 0) m_cnt[i] = max_of(i);
        end else if (m_tick_now && len_en[i] && m_cnt[i] > 0) begin
          m_cnt[i] = m_cnt[i] - 1;
          m_exp    = (m_cnt[i] == 0);
        end
        if (!dac_en[i])   m_act[i] = 1'b0;
        else if (trig[i]) m_act[i] = 1'b1;
        else if (m_exp)   m_act[i] = 1'b0;
        m_start[i] = trig[i] & dac_en[i];
      end
      en_cyc = en_cyc + 1;
      m_step = (en_cyc / FD) % 8;
      m_lt   = (en_cyc % FD == 0) && (m_step % 2 == 0);
      m_st   = (en_cyc % FD == 0) && (m_step == 2 || m_step == 6);
      m_et   = (en_cyc % FD == 0) && (m_step == 7);
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; master_en = 1'b1;
    trig = 4'hF; len_load = 4'hF; len_en = 4'hF; dac_en = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got=%h want=%h", dut_vec(), 14'd0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_cnt(i) !== 9'd0) begin
        errors++; $display("FAIL reset_cnt%0d got=%0d want=0", i, dut_cnt(i));
      end
    end
    trig = 4'h0; len_load = 4'h0; len_en = 4'h0; dac_en = 4'h0;
    reset = 1'b0;
  endtask

  task automatic test_strobe_pattern();
    int   first_lt = -1;
    int   lt_n = 0, sw_n = 0, env_n = 0;
    logic prev_any = 1'b0, any;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL strobe_vec cycle=%0d got=%h want=%h", n, dut_vec(), model_vec());
      end
      any = length_tick | sweep_tick | env_tick;
      checks++;
      if (any && prev_any) begin
        errors++; $display("FAIL strobe_adjacent cycle=%0d got=consecutive want=isolated", n);
      end
      prev_any = any;
      if (length_tick === 1'b1) begin lt_n++; if (first_lt < 0) first_lt = n; end
      if (sweep_tick === 1'b1) sw_n++;
      if (env_tick === 1'b1) env_n++;
    end
    checks++;
    if (first_lt != 8) begin errors++; $display("FAIL first_length_tick got=%0d want=8", first_lt); end
    checks++;
    if (lt_n != 5) begin errors++; $display("FAIL length_tick_count got=%0d want=5", lt_n); end
    checks++;
    if (sw_n != 3) begin errors++; $display("FAIL sweep_tick_count got=%0d want=3", sw_n); end
    checks++;
    if (env_n != 1) begin errors++; $display("FAIL env_tick_count got=%0d want=1", env_n); end
  endtask

  task automatic test_sq1_expiry();
    int   ticks = 0;
    logic pend = 1'b0, done = 1'b0, exp_act;
    len_data_sq1 = 6'd62; len_load[0] = 1'b1;
    @(negedge clk);
    len_load[0] = 1'b0;
    checks++;
    if (dut_cnt(0) !== 9'd2) begin errors++; $display("FAIL sq1_load got=%0d want=2", dut_cnt(0)); end
    dac_en[0] = 1'b1; len_en[0] = 1'b1; trig[0] = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    checks++;
    if (ch_start[0] !== 1'b1) begin errors++; $display("FAIL sq1_start got=%b want=1", ch_start[0]); end
    checks++;
    if (ch_active[0] !== 1'b1) begin errors++; $display("FAIL sq1_active got=%b want=1", ch_active[0]); end
    for (int n = 0; n < 40 && !done; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) begin
        checks++;
        if (ch_start[0] !== 1'b0) begin errors++; $display("FAIL sq1_start_width got=%b want=0", ch_start[0]); end
      end
      if (pend) begin
        exp_act = (ticks == 1);
        checks++;
        if (ch_active[0] !== exp_act) begin
          errors++; $display("FAIL sq1_after_tick%0d got=%b want=%b", ticks, ch_active[0], exp_act);
        end
        if (ticks == 2) done = 1'b1;
        pend = 1'b0;
      end
      if (!done && length_tick === 1'b1) begin ticks++; pend = 1'b1; end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL sq1_expiry_timeout got=%0d ticks want=2", ticks); end
    len_en[0] = 1'b0;
  endtask

  task automatic test_wave_reload();
    int ticks = 0;
    checks++;
    if (dut_cnt(2) !== 9'd0) begin errors++; $display("FAIL wave_idle_cnt got=%0d want=0", dut_cnt(2)); end
    dac_en[2] = 1'b1; len_en[2] = 1'b0; trig[2] = 1'b1;
    @(negedge clk);
    trig[2] = 1'b0;
    checks++;
    if (dut_cnt(2) !== 9'd256) begin errors++; $display("FAIL wave_reload got=%0d want=256", dut_cnt(2)); end
    for (int n = 0; n < 200 && ticks < 10; n++) begin
      @(negedge clk);
      if (length_tick === 1'b1) ticks++;
      checks++;
      if (dut_cnt(2) !== 9'd256 || ch_active[2] !== 1'b1) begin
        errors++; $display("FAIL wave_hold got=%0d/%b want=256/1", dut_cnt(2), ch_active[2]);
      end
    end
    checks++;
    if (ticks < 10) begin errors++; $display("FAIL wave_tick_timeout got=%0d want=10", ticks); end
  endtask

  task automatic test_collision();
    logic seen = 1'b0;
    dac_en[1] = 1'b1; len_en[1] = 1'b1; len_data_sq2 = 6'd0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (length_tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL collision_wait got=no_tick want=tick"); end
    len_load[1] = 1'b1;
    @(negedge clk);
    len_load[1] = 1'b0;
    checks++;
    if (dut_cnt(1) !== 9'd64) begin errors++; $display("FAIL collision_cnt got=%0d want=64", dut_cnt(1)); end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (length_tick === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (dut_cnt(1) !== 9'd63) begin errors++; $display("FAIL collision_next_dec got=%0d want=63", dut_cnt(1)); end
  endtask

  task automatic test_dac_off();
    dac_en[3] = 1'b0; trig[3] = 1'b1;
    @(negedge clk);
    trig[3] = 1'b0;
    checks++;
    if (ch_active[3] !== 1'b0 || ch_start[3] !== 1'b0) begin
      errors++; $display("FAIL dac_off_trig got=%b%b want=00", ch_active[3], ch_start[3]);
    end
    dac_en[3] = 1'b1; trig[3] = 1'b1;
    @(negedge clk);
    trig[3] = 1'b0;
    checks++;
    if (ch_active[3] !== 1'b1 || ch_start[3] !== 1'b1) begin
      errors++; $display("FAIL dac_on_trig got=%b%b want=11", ch_active[3], ch_start[3]);
    end
    dac_en[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (ch_active[3] !== 1'b0) begin errors++; $display("FAIL dac_drop got=%b want=0", ch_active[3]); end
  endtask

  task automatic test_power_off();
    logic found = 1'b0;
    logic [2:0] want_step;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (en_cyc % FD == 2 && en_cyc > FD) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL power_off_wait got=no_align want=prescaler2"); end
    master_en = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 14'd0) begin errors++; $display("FAIL power_off_outputs got=%h want=0", dut_vec()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_cnt(i) !== 9'd0) begin errors++; $display("FAIL power_off_cnt%0d got=%0d want=0", i, dut_cnt(i)); end
    end
    dac_en = 4'hF; trig = 4'hF; len_load = 4'hF;
    @(negedge clk);
    trig = 4'h0; len_load = 4'h0;
    checks++;
    if (dut_vec() !== 14'd0 || dut_cnt(0) !== 9'd0 || dut_cnt(2) !== 9'd0) begin
      errors++; $display("FAIL power_off_trig got=%h/%0d want=0/0", dut_vec(), dut_cnt(0));
    end
    master_en = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      want_step = (n == 4) ? 3'd1 : 3'd0;
      checks++;
      if (frame_step !== want_step) begin
        errors++; $display("FAIL reenable_step cycle=%0d got=%0d want=%0d", n, frame_step, want_step);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL rand_vec cycle=%0d got=%h want=%h", n, dut_vec(), model_vec());
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_cnt(i) !== 9'(m_cnt[i])) begin
          errors++; $display("FAIL rand_cnt%0d cycle=%0d got=%0d want=%0d", i, n, dut_cnt(i), m_cnt[i]);
        end
      end
      master_en = ($urandom_range(99) != 0);
      for (int i = 0; i < 4; i++) begin
        trig[i]     = ($urandom_range(7) == 0);
        len_load[i] = ($urandom_range(11) == 0);
      end
      if ($urandom_range(15) == 0) len_en = 4'($urandom);
      if ($urandom_range(31) == 0) dac_en = 4'($urandom) | 4'($urandom);
      len_data_sq1   = 6'($urandom_range(63, 56));
      len_data_sq2   = 6'($urandom_range(63, 56));
      len_data_noise = 6'($urandom_range(63, 56));
      len_data_wave  = 8'($urandom_range(255, 248));
    end
    trig = 4'h0; len_load = 4'h0; master_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    reset = 1'b1; master_en = 1'b0;
    trig = 4'h0; len_en = 4'h0; len_load = 4'h0; dac_en = 4'h0;
    len_data_sq1 = 6'd0; len_data_sq2 = 6'd0; len_data_noise = 6'd0; len_data_wave = 8'd0;
    test_reset();
    test_strobe_pattern();
    test_sq1_expiry();
    test_wave_reload();
    test_collision();
    test_dac_off();
    test_power_off();
    len_en = 4'hF; dac_en = 4'hF;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
